// File: rtl/program_sequencer.sv
// -----------------------------------------------------------------------------
// program_sequencer
// Holds a small program of 12-bit instructions entered from switches and steps
// through it, driving the register-file/ALU datapath control inputs.
//
// Instruction format:
//   [11]=0      ALU op : ALUSel=[10:9] dest=[8:6] src1=[5:3] src2=[2:0]
//   [11:10]=10  LOADI  : dest=[8:6] imm=[3:0]
//   [11:10]=11  HALT
//
// Ports:
//   clk, rst (async, active-low)
//   mode        0 = LOAD program, 1 = RUN program
//   instr_in    instruction from switches
//   load_pulse  store instr_in at the write pointer (LOAD mode)
//   step_pulse  execute one instruction (RUN mode)
//   AddrSrc1/AddrSrc2/AddrDest/ALUSel/isExternal/EXTDATA  datapath controls
//   wr_en       one-cycle register-file write strobe
//   pc          current program counter
//   busy        instruction in flight
//   halted      a HALT has executed since the last RUN entry
//
// Optional feature: define AUTO_RUN_EN to add a free-running step generator
// that issues a step every AUTO_DIV cycles in RUN mode.
// -----------------------------------------------------------------------------
module program_sequencer #(
   parameter int DEPTH    = 8,
   parameter int AUTO_DIV = 25000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mode,
   input  logic [11:0]              instr_in,
   input  logic                     load_pulse,
   input  logic                     step_pulse,
   output logic [2:0]               AddrSrc1,
   output logic [2:0]               AddrSrc2,
   output logic [2:0]               AddrDest,
   output logic [1:0]               ALUSel,
   output logic                     isExternal,
   output logic [3:0]               EXTDATA,
   output logic                     wr_en,
   output logic [$clog2(DEPTH)-1:0] pc,
   output logic                     busy,
   output logic                     halted
);

   localparam int              PW         = $clog2(DEPTH);
   localparam logic [11:0]     HALT_INSTR = 12'hC00;
   localparam logic [PW-1:0]   PC_ONE     = PW'(32'd1);
   localparam logic [PW-1:0]   PC_ZERO    = PW'(32'd0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t        state_r, state_s;
   logic          busy_r, busy_s;
   logic [11:0]   mem_r [DEPTH];
   logic [11:0]   ir_r;
   logic [PW-1:0] wptr_r, pc_r;
   logic          mode_q_r, mode_rise_s, inflight_s, step_req_s;
   logic          restart_pend_r, halted_r, wr_en_r;
   logic [2:0]    src1_r, src2_r, dest_r;
   logic [1:0]    alusel_r;
   logic          isext_r;
   logic [3:0]    extdata_r;

   assign mode_rise_s = mode & ~mode_q_r;
   assign inflight_s  = (state_r == S_FETCH) || (state_r == S_EXEC) || (state_r == S_WB);

`ifdef AUTO_RUN_EN
   localparam logic [31:0] AUTO_LAST = 32'(AUTO_DIV - 1);
   logic [31:0] auto_cnt_r;
   logic        auto_tick_s;

   assign auto_tick_s = mode && (state_r != S_HALTED) && (auto_cnt_r == AUTO_LAST);
   assign step_req_s  = step_pulse | auto_tick_s;

   // Auto-step divider: restarts on RUN entry, idles in LOAD mode and once halted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         auto_cnt_r <= 32'd0;
      end else if (mode_rise_s || !mode || (state_r == S_HALTED) || auto_tick_s) begin
         auto_cnt_r <= 32'd0;
      end else begin
         auto_cnt_r <= auto_cnt_r + 32'd1;
      end
   end
`else
   assign step_req_s = step_pulse;
`endif

   // FSM state register and registered busy flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= S_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= busy_s;
      end
   end

   // Next-state logic; steps are only accepted from IDLE, so pulses while busy drop
   always_comb begin
      state_s = state_r;
      busy_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (mode && step_req_s) state_s = S_FETCH;
            else                    state_s = S_IDLE;
         end
         S_FETCH: state_s = S_EXEC;
         S_EXEC: begin
            if (ir_r[11:10] == 2'b11) state_s = S_HALTED;
            else                      state_s = S_WB;
         end
         S_WB: state_s = S_IDLE;
         S_HALTED: begin
            if (!mode || restart_pend_r || mode_rise_s) state_s = S_IDLE;
            else                                        state_s = S_HALTED;
         end
         default: state_s = S_IDLE;
      endcase
      busy_s = (state_s == S_FETCH) || (state_s == S_EXEC) || (state_s == S_WB);
   end

   // Program memory, pointers, instruction register and registered datapath controls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= HALT_INSTR;
         ir_r           <= 12'h000;
         wptr_r         <= PC_ZERO;
         pc_r           <= PC_ZERO;
         mode_q_r       <= 1'b0;
         restart_pend_r <= 1'b0;
         halted_r       <= 1'b0;
         wr_en_r        <= 1'b0;
         src1_r         <= 3'd0;
         src2_r         <= 3'd0;
         dest_r         <= 3'd0;
         alusel_r       <= 2'd0;
         isext_r        <= 1'b0;
         extdata_r      <= 4'd0;
      end else begin
         mode_q_r <= mode;
         // Loads are held off while an instruction is still completing
         if (!mode && load_pulse && !inflight_s) begin
            mem_r[wptr_r] <= instr_in;
            wptr_r        <= wptr_r + PC_ONE;
         end
         case (state_r)
            S_FETCH: begin
               ir_r <= mem_r[pc_r];
               if (mode_rise_s) restart_pend_r <= 1'b1;
            end
            S_EXEC: begin
               if (mode_rise_s) restart_pend_r <= 1'b1;
               case (ir_r[11:10])
                  2'b10: begin
                     // LOADI: source addresses are don't-care and left as they were
                     dest_r    <= ir_r[8:6];
                     alusel_r  <= 2'b00;
                     isext_r   <= 1'b1;
                     extdata_r <= ir_r[3:0];
                     wr_en_r   <= 1'b1;
                  end
                  2'b11: begin
                     isext_r  <= 1'b0;
                     halted_r <= 1'b1;
                  end
                  default: begin
                     src1_r    <= ir_r[5:3];
                     src2_r    <= ir_r[2:0];
                     dest_r    <= ir_r[8:6];
                     alusel_r  <= ir_r[10:9];
                     isext_r   <= 1'b0;
                     extdata_r <= 4'd0;
                     wr_en_r   <= 1'b1;
                  end
               endcase
            end
            S_WB: begin
               wr_en_r <= 1'b0;
               // A RUN re-entry seen mid-instruction takes effect once it retires
               if (restart_pend_r || mode_rise_s) begin
                  pc_r           <= PC_ZERO;
                  halted_r       <= 1'b0;
                  restart_pend_r <= 1'b0;
               end else begin
                  pc_r <= pc_r + PC_ONE;
               end
            end
            S_HALTED: begin
               if (restart_pend_r || mode_rise_s) begin
                  pc_r           <= PC_ZERO;
                  halted_r       <= 1'b0;
                  restart_pend_r <= 1'b0;
               end
            end
            default: begin
               if (mode_rise_s) begin
                  pc_r     <= PC_ZERO;
                  halted_r <= 1'b0;
               end
            end
         endcase
      end
   end

   assign AddrSrc1   = src1_r;
   assign AddrSrc2   = src2_r;
   assign AddrDest   = dest_r;
   assign ALUSel     = alusel_r;
   assign isExternal = isext_r;
   assign EXTDATA    = extdata_r;
   assign wr_en      = wr_en_r;
   assign pc         = pc_r;
   assign busy       = busy_r;
   assign halted     = halted_r;

endmodule

// File: tb/tb_program_sequencer.sv
// -----------------------------------------------------------------------------
// tb_program_sequencer
// Directed and randomized checks of program_sequencer (DEPTH=8) against a
// program-level reference model: an array holding the loaded program, a
// write pointer, a program counter, a halted flag and the expected control
// vector {AddrSrc1,AddrSrc2,AddrDest,ALUSel,isExternal,EXTDATA}.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_program_sequencer;

   logic        clk = 1'b0;
   logic        rst, mode, load_pulse, step_pulse;
   logic [11:0] instr_in;
   logic [2:0]  AddrSrc1, AddrSrc2, AddrDest;
   logic [1:0]  ALUSel;
   logic        isExternal, wr_en, busy, halted;
   logic [3:0]  EXTDATA;
   logic [2:0]  pc;
   logic [15:0] outs;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [11:0] m_mem [8];
   int          m_wptr, m_pc;
   logic        m_halted;
   logic [15:0] m_outs;

   program_sequencer #(.DEPTH(8), .AUTO_DIV(16)) dut (
      .clk(clk), .rst(rst), .mode(mode), .instr_in(instr_in),
      .load_pulse(load_pulse), .step_pulse(step_pulse),
      .AddrSrc1(AddrSrc1), .AddrSrc2(AddrSrc2), .AddrDest(AddrDest),
      .ALUSel(ALUSel), .isExternal(isExternal), .EXTDATA(EXTDATA),
      .wr_en(wr_en), .pc(pc), .busy(busy), .halted(halted)
   );

   assign outs = {AddrSrc1, AddrSrc2, AddrDest, ALUSel, isExternal, EXTDATA};

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_mem[i] = 12'hC00;
      m_wptr = 0; m_pc = 0; m_halted = 1'b0; m_outs = 16'h0000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; mode = 1'b0; load_pulse = 1'b0; step_pulse = 1'b0; instr_in = 12'h000;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   task automatic load_instr(input logic [11:0] v);
      @(negedge clk);
      instr_in = v; load_pulse = 1'b1;
      @(negedge clk);
      load_pulse = 1'b0;
      if (!mode) begin
         m_mem[m_wptr] = v;
         m_wptr = (m_wptr + 1) % 8;
      end
   endtask

   task automatic set_mode(input logic v);
      @(negedge clk);
      if (v && !mode) begin
         m_pc = 0; m_halted = 1'b0;
      end
      mode = v;
      repeat (2) @(negedge clk);
   endtask

   // one step pulse, then watch five samples; wr_en is expected on the third
   task automatic do_step(output int wr_cnt, output int wr_idx);
      @(negedge clk);
      step_pulse = 1'b1;
      @(negedge clk);
      step_pulse = 1'b0;
      wr_cnt = 0; wr_idx = -1;
      for (int i = 1; i <= 5; i++) begin
         if (wr_en === 1'b1) begin wr_cnt++; wr_idx = i; end
         if (i < 5) @(negedge clk);
      end
   endtask

   // program-level effect of one step request
   task automatic model_step(output int exp_wr);
      logic [11:0] ins;
      exp_wr = 0;
      if (mode && !m_halted) begin
         ins = m_mem[m_pc];
         if (ins[11] == 1'b0) begin
            m_outs = {ins[5:3], ins[2:0], ins[8:6], ins[10:9], 1'b0, 4'h0};
            exp_wr = 1;
            m_pc = (m_pc + 1) % 8;
         end else if (ins[10] == 1'b0) begin
            m_outs = {m_outs[15:10], ins[8:6], 2'b00, 1'b1, ins[3:0]};
            exp_wr = 1;
            m_pc = (m_pc + 1) % 8;
         end else begin
            m_outs[4] = 1'b0;
            m_halted = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      int wc, wi, ew;
      @(negedge clk);
      rst = 1'b0; mode = 1'b0; load_pulse = 1'b0; step_pulse = 1'b0; instr_in = 12'h000;
      repeat (2) @(negedge clk);
      n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0b expected 0", wr_en); end
      n_checks++; if (pc !== 3'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", pc); end
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b expected 0", halted); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      n_checks++; if (outs !== 16'h0000) begin n_fail++; $display("FAIL reset_outputs: got %04h expected 0000", outs); end
      rst = 1'b1;
      model_reset();
      set_mode(1'b1);
      do_step(wc, wi);
      model_step(ew);
      n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL reset_mem_halt_wr: got %0d strobes expected 0", wc); end
      n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL reset_mem_halt: got %0b expected 1", halted); end
      n_checks++; if (pc !== 3'd0) begin n_fail++; $display("FAIL reset_mem_halt_pc: got %0d expected 0", pc); end
   endtask

   task automatic test_loadi();
      int wc, wi, ew;
      do_reset();
      load_instr(12'h853);
      load_instr(12'hC00);
      set_mode(1'b1);
      do_step(wc, wi);
      model_step(ew);
      n_checks++; if (wc !== 1) begin n_fail++; $display("FAIL loadi_wr_count: got %0d expected 1", wc); end
      n_checks++; if (wi !== 3) begin n_fail++; $display("FAIL loadi_wr_latency: got %0d expected 3", wi); end
      n_checks++; if (isExternal !== 1'b1) begin n_fail++; $display("FAIL loadi_isext: got %0b expected 1", isExternal); end
      n_checks++; if (EXTDATA !== 4'd3) begin n_fail++; $display("FAIL loadi_extdata: got %0d expected 3", EXTDATA); end
      n_checks++; if (AddrDest !== 3'd1) begin n_fail++; $display("FAIL loadi_dest: got %0d expected 1", AddrDest); end
      n_checks++; if (pc !== 3'd1) begin n_fail++; $display("FAIL loadi_pc: got %0d expected 1", pc); end
   endtask

   task automatic test_halt();
      int wc, wi, ew;
      do_step(wc, wi);
      model_step(ew);
      n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL halt_wr: got %0d strobes expected 0", wc); end
      n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %0b expected 1", halted); end
      n_checks++; if (isExternal !== 1'b0) begin n_fail++; $display("FAIL halt_isext: got %0b expected 0", isExternal); end
      n_checks++; if (AddrDest !== 3'd1) begin n_fail++; $display("FAIL halt_dest_held: got %0d expected 1", AddrDest); end
      for (int k = 0; k < 2; k++) begin
         do_step(wc, wi);
         model_step(ew);
         n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL halt_ignore_wr: got %0d strobes expected 0", wc); end
         n_checks++; if (pc !== 3'd1) begin n_fail++; $display("FAIL halt_ignore_pc: got %0d expected 1", pc); end
      end
   endtask

   task automatic test_alu();
      int wc, wi, ew;
      do_reset();
      load_instr(12'h24A);
      set_mode(1'b1);
      do_step(wc, wi);
      model_step(ew);
      n_checks++; if (wc !== 1) begin n_fail++; $display("FAIL alu_wr_count: got %0d expected 1", wc); end
      n_checks++; if (ALUSel !== 2'd1) begin n_fail++; $display("FAIL alu_sel: got %0d expected 1", ALUSel); end
      n_checks++; if (AddrSrc1 !== 3'd1) begin n_fail++; $display("FAIL alu_src1: got %0d expected 1", AddrSrc1); end
      n_checks++; if (AddrSrc2 !== 3'd2) begin n_fail++; $display("FAIL alu_src2: got %0d expected 2", AddrSrc2); end
      n_checks++; if (AddrDest !== 3'd1) begin n_fail++; $display("FAIL alu_dest: got %0d expected 1", AddrDest); end
      n_checks++; if (isExternal !== 1'b0) begin n_fail++; $display("FAIL alu_isext: got %0b expected 0", isExternal); end
   endtask

   task automatic test_wrap_drop();
      int wc, wi, ew;
      logic [11:0] v, ninth;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         v = {1'b0, 11'($urandom())};
         load_instr(v);
         ninth = v;
      end
      set_mode(1'b1);
      // step held for two cycles: the second sample lands while busy
      @(negedge clk);
      step_pulse = 1'b1;
      @(negedge clk);
      wc = 0;
      if (wr_en === 1'b1) wc++;
      @(negedge clk);
      step_pulse = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (wr_en === 1'b1) wc++;
         @(negedge clk);
      end
      model_step(ew);
      n_checks++; if (wc !== 1) begin n_fail++; $display("FAIL drop_wr_count: got %0d expected 1", wc); end
      n_checks++; if (pc !== 3'd1) begin n_fail++; $display("FAIL drop_pc: got %0d expected 1", pc); end
      n_checks++; if (AddrDest !== ninth[8:6]) begin n_fail++; $display("FAIL wrap_overwrite_dest: got %0d expected %0d", AddrDest, ninth[8:6]); end
      n_checks++; if (AddrSrc1 !== ninth[5:3]) begin n_fail++; $display("FAIL wrap_overwrite_src1: got %0d expected %0d", AddrSrc1, ninth[5:3]); end
      for (int k = 0; k < 7; k++) begin
         do_step(wc, wi);
         model_step(ew);
         n_checks++; if (wc !== 1) begin n_fail++; $display("FAIL wrap_step%0d_wr: got %0d expected 1", k, wc); end
      end
      n_checks++; if (pc !== 3'd0) begin n_fail++; $display("FAIL wrap_pc: got %0d expected 0", pc); end
      n_checks++; if (outs !== m_outs) begin n_fail++; $display("FAIL wrap_outputs: got %04h expected %04h", outs, m_outs); end
   endtask

   task automatic test_reset_midop();
      int wc, wi, ew;
      do_reset();
      load_instr(12'h24A);
      load_instr(12'h853);
      set_mode(1'b1);
      @(negedge clk);
      step_pulse = 1'b1;
      @(negedge clk);
      step_pulse = 1'b0;
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midop_busy: got %0b expected 1", busy); end
      rst = 1'b0;
      wc = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (wr_en === 1'b1) wc++;
         @(negedge clk);
      end
      n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL midop_wr: got %0d strobes expected 0", wc); end
      n_checks++; if (outs !== 16'h0000) begin n_fail++; $display("FAIL midop_outputs: got %04h expected 0000", outs); end
      n_checks++; if (pc !== 3'd0) begin n_fail++; $display("FAIL midop_pc: got %0d expected 0", pc); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midop_busy_clr: got %0b expected 0", busy); end
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      do_step(wc, wi);
      model_step(ew);
      n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL midop_mem_reinit_wr: got %0d expected 0", wc); end
      n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL midop_mem_reinit: got %0b expected 1", halted); end
   endtask

   task automatic test_random();
      int wc, wi, ew, n, r;
      logic [11:0] v;
      do_reset();
      for (int round = 0; round < 8; round++) begin
         set_mode(1'b0);
         n_checks++; if (halted !== m_halted) begin n_fail++; $display("FAIL rnd_load_halted: got %0b expected %0b", halted, m_halted); end
         do_step(wc, wi);
         model_step(ew);
         n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL rnd_load_step_ignored: got %0d expected 0", wc); end
         n = $urandom_range(1, 8);
         for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 9);
            v = 12'($urandom());
            if (r < 6)      v[11] = 1'b0;
            else if (r < 9) v[11:10] = 2'b10;
            else            v[11:10] = 2'b11;
            load_instr(v);
         end
         set_mode(1'b1);
         load_instr(12'hC00);
         n = $urandom_range(3, 10);
         for (int k = 0; k < n; k++) begin
            do_step(wc, wi);
            model_step(ew);
            n_checks++; if (wc !== ew) begin n_fail++; $display("FAIL rnd_wr_count: got %0d expected %0d", wc, ew); end
            if (ew == 1) begin
               n_checks++; if (wi !== 3) begin n_fail++; $display("FAIL rnd_wr_latency: got %0d expected 3", wi); end
            end
            n_checks++; if (outs !== m_outs) begin n_fail++; $display("FAIL rnd_outputs: got %04h expected %04h", outs, m_outs); end
            n_checks++; if (pc !== 3'(m_pc)) begin n_fail++; $display("FAIL rnd_pc: got %0d expected %0d", pc, m_pc); end
            n_checks++; if (halted !== m_halted) begin n_fail++; $display("FAIL rnd_halted: got %0b expected %0b", halted, m_halted); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_busy_idle: got %0b expected 0", busy); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; load_pulse = 1'b0; step_pulse = 1'b0; instr_in = 12'h000;
      model_reset();
      test_reset();
      test_loadi();
      test_halt();
      test_alu();
      test_wrap_drop();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
